// File: rtl/seq_pkg.sv
// Shared constants for the serial pattern generator: default widths and
// the legacy-compatible FSM state encoding.
package seq_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int REP_W_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SEND = 2'b01;
  localparam logic [1:0] ST_GAP  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

endpackage

// File: rtl/seq_gen.sv
// Serial pattern generator: shifts out bit[len-1]..bit[0] of a latched
// pattern, repeated rpt+1 times with a one-cycle gap between repeats,
// then pulses done for one cycle. All outputs come straight from flops.
module seq_gen
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [PAT_W-1:0]       pattern,
  input  logic [$clog2(PAT_W):0] len,
  input  logic [REP_W-1:0]       rpt,
  output logic                   out,
  output logic                   valid,
  output logic                   busy,
  output logic                   done
);

  localparam int IW = $clog2(PAT_W);
  localparam int LW = IW + 1;

  localparam logic [LW-1:0]    LEN_ZERO = LW'(0);
  localparam logic [LW-1:0]    LEN_ONE  = LW'(1);
  localparam logic [LW-1:0]    LEN_MAX  = LW'(PAT_W);
  localparam logic [IW-1:0]    IDX_ZERO = IW'(0);
  localparam logic [IW-1:0]    IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]    IDX_MAX  = IW'(PAT_W - 1);
  localparam logic [REP_W-1:0] REP_ZERO = REP_W'(0);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  // Index of the first bit to send; out-of-range lengths mean a full pattern.
  function automatic logic [IW-1:0] top_index(input logic [LW-1:0] l);
    logic [IW-1:0] t;
    if ((l == LEN_ZERO) || (l > LEN_MAX)) begin
      t = IDX_MAX;
    end else begin
      t = IW'(l - LEN_ONE);
    end
    return t;
  endfunction

  logic [1:0]       state_r, state_s;
  logic [PAT_W-1:0] pat_r,   pat_s;
  logic [IW-1:0]    top_r,   top_s;   // latched length, kept as top bit index
  logic [IW-1:0]    idx_r,   idx_s;   // index of the bit currently on out
  logic [REP_W-1:0] rep_r,   rep_s;   // repetitions still to send
  logic             out_r,   out_s;
  logic             valid_r, valid_s;
  logic             busy_r,  busy_s;
  logic             done_r,  done_s;

  // Next-state and next-output decode; outputs describe the cycle after the edge.
  always_comb begin
    state_s = state_r;
    pat_s   = pat_r;
    top_s   = top_r;
    idx_s   = idx_r;
    rep_s   = rep_r;
    out_s   = 1'b0;
    valid_s = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_SEND;
          pat_s   = pattern;
          top_s   = top_index(len);
          idx_s   = top_index(len);
          rep_s   = rpt;
          out_s   = pattern[top_index(len)];
          valid_s = 1'b1;
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        busy_s = 1'b1;
        if (idx_r != IDX_ZERO) begin
          idx_s   = idx_r - IDX_ONE;
          out_s   = pat_r[idx_s];
          valid_s = 1'b1;
        end else if (rep_r != REP_ZERO) begin
          state_s = ST_GAP;
        end else begin
          state_s = ST_DONE;
          done_s  = 1'b1;
        end
      end
      ST_GAP: begin
        state_s = ST_SEND;
        idx_s   = top_r;
        rep_s   = rep_r - REP_ONE;
        out_s   = pat_r[top_r];
        valid_s = 1'b1;
        busy_s  = 1'b1;
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, job context and output registers; reset abandons any job silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pat_r   <= '0;
      top_r   <= IDX_ZERO;
      idx_r   <= IDX_ZERO;
      rep_r   <= REP_ZERO;
      out_r   <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      pat_r   <= pat_s;
      top_r   <= top_s;
      idx_r   <= idx_s;
      rep_r   <= rep_s;
      out_r   <= out_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign out   = out_r;
  assign valid = valid_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule
